// File: rtl/bomberman_move_ctrl.sv
// bomberman_move_ctrl
//   Player movement and bomb-placement controller for a Bomberman-style grid.
//   Button pulses are latched as pending requests. Directions are arbitrated
//   round-robin (UP, DOWN, LEFT, RIGHT). Each granted move is bounds-checked,
//   looked up in the tile map, committed when the tile is free, and then
//   followed by a move cooldown.
//
// Build option:
//   BOMBERMAN_BOMB_EN  When defined, MID_SCEN places a bomb. A pending MID beats
//                      any pending direction, and an independent bomb cooldown
//                      runs. When undefined, MID_SCEN is ignored and BOMB_PLACE
//                      is tied low.
//
// Ports:
//   CLK, RESET_N                         clock, async active-low reset
//   UP/DOWN/LEFT/RIGHT/MID_SCEN          single-cycle button pulses
//   MAP_REQ, MAP_X, MAP_Y                tile lookup request and coordinates
//   MAP_ACK, MAP_WALL                    lookup done / tile blocked
//   PLAYER_X, PLAYER_Y                   current player position
//   BOMB_PLACE                           one-cycle bomb placement pulse
//   BUSY                                 high whenever the FSM is not IDLE
module bomberman_move_ctrl #(
  parameter int GRID_W  = 15,
  parameter int GRID_H  = 11,
  parameter int START_X = 1,
  parameter int START_Y = 1,
  parameter int MOVE_CD = 8,
  parameter int BOMB_CD = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       UP_SCEN,
  input  logic       DOWN_SCEN,
  input  logic       LEFT_SCEN,
  input  logic       RIGHT_SCEN,
  input  logic       MID_SCEN,
  output logic       MAP_REQ,
  output logic [3:0] MAP_X,
  output logic [3:0] MAP_Y,
  input  logic       MAP_ACK,
  input  logic       MAP_WALL,
  output logic [3:0] PLAYER_X,
  output logic [3:0] PLAYER_Y,
  output logic       BOMB_PLACE,
  output logic       BUSY
);

  typedef enum logic [2:0] {IDLE, BOUND, LOOKUP, COMMIT, COOL} state_e;

  localparam int MCW = (MOVE_CD < 2) ? 1 : $clog2(MOVE_CD + 1);

  // Reset asserts asynchronously; release is delayed two edges so every
  // state flop leaves reset on the same clock edge.
  logic [1:0] rstSync_q;
  logic       rstInt_n;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rstSync_q <= 2'b00;
    else          rstSync_q <= {rstSync_q[0], 1'b1};
  end
  assign rstInt_n = rstSync_q[1];

  state_e           state_q, state_d;
  logic [3:0]       dirPend_q, dirPend_d, dirClr;
  logic [1:0]       rrPtr_q, rrPtr_d;
  logic [4:0]       tgtX_q, tgtX_d, tgtY_q, tgtY_d;
  logic [3:0]       mapX_q, mapX_d, mapY_q, mapY_d;
  logic [3:0]       playerX_q, playerX_d, playerY_q, playerY_d;
  logic [MCW-1:0]   moveCd_q, moveCd_d;
  logic [3:0]       dirScen;
  logic [1:0]       grantIdx, idx;
  logic             dirFound;

  assign dirScen = {RIGHT_SCEN, LEFT_SCEN, DOWN_SCEN, UP_SCEN};

`ifdef BOMBERMAN_BOMB_EN
  localparam int BCW = (BOMB_CD < 2) ? 1 : $clog2(BOMB_CD + 1);
  logic           midPend_q, midPend_d;
  logic [BCW-1:0] bombCd_q, bombCd_d;
  logic           bombPlace_q, bombPlace_d;
`else
  localparam int unusedBombCd = BOMB_CD;
  logic unusedMid;
  assign unusedMid = MID_SCEN;
`endif

  // Round-robin search over the pending directions, starting at the pointer.
  always_comb begin
    grantIdx = rrPtr_q;
    dirFound = 1'b0;
    idx      = '0;
    for (int i = 0; i < 4; i++) begin
      idx = rrPtr_q + 2'(i);
      if (!dirFound && dirPend_q[idx]) begin
        dirFound = 1'b1;
        grantIdx = idx;
      end
    end
  end

  // Next-state logic. The target is held one bit wider than the grid so a
  // step off the low edge wraps to a large value and fails the bounds test.
  always_comb begin
    state_d   = state_q;
    dirClr    = '0;
    rrPtr_d   = rrPtr_q;
    tgtX_d    = tgtX_q;
    tgtY_d    = tgtY_q;
    mapX_d    = mapX_q;
    mapY_d    = mapY_q;
    playerX_d = playerX_q;
    playerY_d = playerY_q;
    moveCd_d  = moveCd_q;
`ifdef BOMBERMAN_BOMB_EN
    midPend_d   = midPend_q | MID_SCEN;
    bombPlace_d = 1'b0;
    bombCd_d    = (bombCd_q != '0) ? bombCd_q - BCW'(1) : '0;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef BOMBERMAN_BOMB_EN
        if (midPend_q) begin
          midPend_d = MID_SCEN;
          if (bombCd_q == '0) begin
            bombPlace_d = 1'b1;
            bombCd_d    = BCW'(BOMB_CD);
          end
        end else
`endif
        if (dirFound && moveCd_q == '0) begin
          dirClr[grantIdx] = 1'b1;
          rrPtr_d = grantIdx + 2'd1;
          tgtX_d  = {1'b0, playerX_q};
          tgtY_d  = {1'b0, playerY_q};
          unique case (grantIdx)
            2'd0:    tgtY_d = {1'b0, playerY_q} - 5'd1;
            2'd1:    tgtY_d = {1'b0, playerY_q} + 5'd1;
            2'd2:    tgtX_d = {1'b0, playerX_q} - 5'd1;
            default: tgtX_d = {1'b0, playerX_q} + 5'd1;
          endcase
          state_d = BOUND;
        end
      end
      BOUND: begin
        if (tgtX_q < 5'(GRID_W) && tgtY_q < 5'(GRID_H)) begin
          mapX_d  = tgtX_q[3:0];
          mapY_d  = tgtY_q[3:0];
          state_d = LOOKUP;
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        if (MAP_ACK) state_d = MAP_WALL ? IDLE : COMMIT;
      end
      COMMIT: begin
        playerX_d = tgtX_q[3:0];
        playerY_d = tgtY_q[3:0];
        moveCd_d  = MCW'(MOVE_CD);
        state_d   = COOL;
      end
      COOL: begin
        if (moveCd_q <= MCW'(1)) begin
          moveCd_d = '0;
          state_d  = IDLE;
        end else begin
          moveCd_d = moveCd_q - MCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    dirPend_d = (dirPend_q & ~dirClr) | dirScen;
  end

  // Main state register.
  always_ff @(posedge CLK or negedge rstInt_n) begin
    if (!rstInt_n) begin
      state_q   <= IDLE;
      dirPend_q <= '0;
      rrPtr_q   <= '0;
      tgtX_q    <= '0;
      tgtY_q    <= '0;
      mapX_q    <= '0;
      mapY_q    <= '0;
      playerX_q <= 4'(START_X);
      playerY_q <= 4'(START_Y);
      moveCd_q  <= '0;
    end else begin
      state_q   <= state_d;
      dirPend_q <= dirPend_d;
      rrPtr_q   <= rrPtr_d;
      tgtX_q    <= tgtX_d;
      tgtY_q    <= tgtY_d;
      mapX_q    <= mapX_d;
      mapY_q    <= mapY_d;
      playerX_q <= playerX_d;
      playerY_q <= playerY_d;
      moveCd_q  <= moveCd_d;
    end
  end

`ifdef BOMBERMAN_BOMB_EN
  // Bomb request, cooldown and placement pulse.
  always_ff @(posedge CLK or negedge rstInt_n) begin
    if (!rstInt_n) begin
      midPend_q   <= 1'b0;
      bombCd_q    <= '0;
      bombPlace_q <= 1'b0;
    end else begin
      midPend_q   <= midPend_d;
      bombCd_q    <= bombCd_d;
      bombPlace_q <= bombPlace_d;
    end
  end
  assign BOMB_PLACE = bombPlace_q;
`else
  assign BOMB_PLACE = 1'b0;
`endif

  assign MAP_REQ  = (state_q == LOOKUP);
  assign MAP_X    = mapX_q;
  assign MAP_Y    = mapY_q;
  assign PLAYER_X = playerX_q;
  assign PLAYER_Y = playerY_q;
  assign BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_bomberman_move_ctrl.sv
// Testbench for bomberman_move_ctrl. Expected lookups, moves and bomb pulses
// are queued as each stimulus is applied. A negedge monitor pops and compares
// them as the DUT produces them.
module tb_bomberman_move_ctrl;

  localparam int K_LOOKUP = 0;
  localparam int K_MOVE   = 1;
  localparam int K_BOMB   = 2;

  localparam logic [4:0] S_UP    = 5'b00001;
  localparam logic [4:0] S_DOWN  = 5'b00010;
  localparam logic [4:0] S_LEFT  = 5'b00100;
  localparam logic [4:0] S_RIGHT = 5'b01000;
  localparam logic [4:0] S_MID   = 5'b10000;

  typedef struct {
    int kind;
    int x;
    int y;
  } sbItem_t;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       UP_SCEN, DOWN_SCEN, LEFT_SCEN, RIGHT_SCEN, MID_SCEN;
  logic       MAP_REQ, MAP_ACK, MAP_WALL, BOMB_PLACE, BUSY;
  logic [3:0] MAP_X, MAP_Y, PLAYER_X, PLAYER_Y;

  sbItem_t sbQ[$];
  int      nCompared   = 0;
  int      nMismatched = 0;
  int      bombCount   = 0;
  bit      monitorOn   = 1'b0;
  logic       reqPrev  = 1'b0;
  logic [3:0] pxPrev   = 4'd0;
  logic [3:0] pyPrev   = 4'd0;

  bomberman_move_ctrl dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .UP_SCEN(UP_SCEN), .DOWN_SCEN(DOWN_SCEN), .LEFT_SCEN(LEFT_SCEN),
    .RIGHT_SCEN(RIGHT_SCEN), .MID_SCEN(MID_SCEN),
    .MAP_REQ(MAP_REQ), .MAP_X(MAP_X), .MAP_Y(MAP_Y),
    .MAP_ACK(MAP_ACK), .MAP_WALL(MAP_WALL),
    .PLAYER_X(PLAYER_X), .PLAYER_Y(PLAYER_Y),
    .BOMB_PLACE(BOMB_PLACE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic expectEvent(input int kind, input int x, input int y);
    sbItem_t item;
    item.kind = kind;
    item.x    = x;
    item.y    = y;
    sbQ.push_back(item);
  endtask

  task automatic scoreEvent(input int kind, input int x, input int y);
    sbItem_t item;
    if (sbQ.size() == 0) begin
      checkOutput("sbUnexpected", sbQ.size(), 1);
    end else begin
      item = sbQ.pop_front();
      checkOutput("sbKind", kind, item.kind);
      checkOutput("sbX", x, item.x);
      checkOutput("sbY", y, item.y);
    end
  endtask

  // Observes lookup starts, position changes and bomb pulses.
  always @(negedge CLK) begin
    if (monitorOn) begin
      if (MAP_REQ && !reqPrev) scoreEvent(K_LOOKUP, MAP_X, MAP_Y);
      if (PLAYER_X != pxPrev || PLAYER_Y != pyPrev) scoreEvent(K_MOVE, PLAYER_X, PLAYER_Y);
      if (BOMB_PLACE) begin
        bombCount++;
        scoreEvent(K_BOMB, PLAYER_X, PLAYER_Y);
      end
    end
    reqPrev = MAP_REQ;
    pxPrev  = PLAYER_X;
    pyPrev  = PLAYER_Y;
  end

  task automatic applyReset();
    @(posedge CLK);
    #2;
    monitorOn = 1'b0;
    RESET_N   = 1'b0;
    {MID_SCEN, RIGHT_SCEN, LEFT_SCEN, DOWN_SCEN, UP_SCEN} = '0;
    MAP_ACK   = 1'b0;
    MAP_WALL  = 1'b0;
    sbQ.delete();
    @(negedge CLK);
    checkOutput("rstPlayerX", PLAYER_X, 1);
    checkOutput("rstPlayerY", PLAYER_Y, 1);
    checkOutput("rstMapX", MAP_X, 0);
    checkOutput("rstMapY", MAP_Y, 0);
    checkOutput("rstMapReq", MAP_REQ, 0);
    checkOutput("rstBusy", BUSY, 0);
    checkOutput("rstBomb", BOMB_PLACE, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK);
    monitorOn = 1'b1;
  endtask

  // One-cycle pulse on the selected buttons; returns one negedge later.
  task automatic applyStimulus(input logic [4:0] mask);
    @(negedge CLK);
    {MID_SCEN, RIGHT_SCEN, LEFT_SCEN, DOWN_SCEN, UP_SCEN} = mask;
    @(negedge CLK);
    {MID_SCEN, RIGHT_SCEN, LEFT_SCEN, DOWN_SCEN, UP_SCEN} = '0;
  endtask

  task automatic waitReq(output int waited);
    waited = 0;
    while (!MAP_REQ && waited < 60) begin
      @(negedge CLK);
      waited++;
    end
    if (!MAP_REQ) checkOutput("reqTimeout", MAP_REQ, 1);
  endtask

  task automatic serviceLookup(input bit wall, input int ackDelay, output int waited);
    waitReq(waited);
    if (MAP_REQ) begin
      repeat (ackDelay) begin
        @(negedge CLK);
        checkOutput("reqHold", MAP_REQ, 1);
      end
      MAP_ACK  = 1'b1;
      MAP_WALL = wall;
      @(negedge CLK);
      MAP_ACK  = 1'b0;
      MAP_WALL = 1'b0;
      checkOutput("reqDrop", MAP_REQ, 0);
      if (wall) checkOutput("wallIdle", BUSY, 0);
    end
  endtask

  task automatic waitIdle(output int busyCycles);
    busyCycles = 0;
    while (BUSY && busyCycles < 60) begin
      busyCycles++;
      @(negedge CLK);
    end
    if (BUSY) checkOutput("idleTimeout", BUSY, 0);
  endtask

  initial begin
    int w;
    int c;
    int expBombs;
    RESET_N = 1'b0;
    {MID_SCEN, RIGHT_SCEN, LEFT_SCEN, DOWN_SCEN, UP_SCEN} = '0;
    MAP_ACK  = 1'b0;
    MAP_WALL = 1'b0;

    // Move right from reset with a two-cycle ACK, then time the cooldown.
    applyReset();
    $display("[TB] right move with cooldown");
    expectEvent(K_LOOKUP, 2, 1);
    expectEvent(K_MOVE, 2, 1);
    applyStimulus(S_RIGHT);
    serviceLookup(1'b0, 2, w);
    @(negedge CLK);
    checkOutput("commitX", PLAYER_X, 2);
    waitIdle(c);
    checkOutput("coolLen", c, 8);
    checkOutput("drain1", sbQ.size(), 0);

    // Row 0 is inside the grid; row -1 is dropped without a lookup.
    applyReset();
    $display("[TB] top edge bounds");
    expectEvent(K_LOOKUP, 1, 0);
    expectEvent(K_MOVE, 1, 0);
    applyStimulus(S_UP);
    serviceLookup(1'b0, 0, w);
    waitIdle(c);
    applyStimulus(S_UP);
    repeat (6) @(negedge CLK);
    checkOutput("edgeY", PLAYER_Y, 0);
    checkOutput("edgeBusy", BUSY, 0);
    checkOutput("edgeReq", MAP_REQ, 0);
    checkOutput("drain2", sbQ.size(), 0);

    // A wall leaves the position alone and leaves no cooldown behind.
    $display("[TB] wall then immediate left");
    expectEvent(K_LOOKUP, 2, 0);
    applyStimulus(S_RIGHT);
    serviceLookup(1'b1, 1, w);
    checkOutput("wallX", PLAYER_X, 1);
    expectEvent(K_LOOKUP, 0, 0);
    expectEvent(K_MOVE, 0, 0);
    applyStimulus(S_LEFT);
    serviceLookup(1'b0, 0, w);
    // Pulse, pending, BOUND, LOOKUP: two negedges after the pulse is cleared.
    checkOutput("noCoolLatency", w, 2);
    waitIdle(c);
    applyStimulus(S_LEFT);
    repeat (6) @(negedge CLK);
    checkOutput("leftEdgeX", PLAYER_X, 0);
    checkOutput("drain3", sbQ.size(), 0);

    // UP and RIGHT together: UP first, then RIGHT. After that the pointer is
    // back at UP, so UP (dropped off the top) is taken before DOWN.
    applyReset();
    $display("[TB] round-robin order");
    expectEvent(K_LOOKUP, 1, 0);
    expectEvent(K_MOVE, 1, 0);
    expectEvent(K_LOOKUP, 2, 0);
    expectEvent(K_MOVE, 2, 0);
    applyStimulus(S_UP | S_RIGHT);
    serviceLookup(1'b0, 0, w);
    serviceLookup(1'b0, 0, w);
    waitIdle(c);
    expectEvent(K_LOOKUP, 2, 1);
    expectEvent(K_MOVE, 2, 1);
    applyStimulus(S_UP | S_DOWN);
    serviceLookup(1'b0, 0, w);
    waitIdle(c);
    repeat (6) @(negedge CLK);
    checkOutput("rrX", PLAYER_X, 2);
    checkOutput("rrY", PLAYER_Y, 1);
    checkOutput("drain4", sbQ.size(), 0);

    // Two MID pulses five cycles apart, then a third after the cooldown.
    $display("[TB] bomb placement");
    bombCount = 0;
`ifdef BOMBERMAN_BOMB_EN
    expBombs = 1;
    expectEvent(K_BOMB, 2, 1);
`else
    expBombs = 0;
`endif
    applyStimulus(S_MID);
    repeat (4) @(negedge CLK);
    applyStimulus(S_MID);
    repeat (25) @(negedge CLK);
    checkOutput("bombFirstPair", bombCount, expBombs);
`ifdef BOMBERMAN_BOMB_EN
    expBombs = 2;
    expectEvent(K_BOMB, 2, 1);
`endif
    applyStimulus(S_MID);
    repeat (4) @(negedge CLK);
    checkOutput("bombAfterCd", bombCount, expBombs);
    checkOutput("bombBusy", BUSY, 0);
    checkOutput("drain5", sbQ.size(), 0);

    // Reset while a lookup is outstanding; a late ACK must be ignored.
    applyReset();
    $display("[TB] reset during lookup");
    expectEvent(K_LOOKUP, 2, 1);
    applyStimulus(S_RIGHT);
    waitReq(w);
    @(posedge CLK);
    #2;
    monitorOn = 1'b0;
    RESET_N   = 1'b0;
    #1;
    checkOutput("reqAbort", MAP_REQ, 0);
    checkOutput("busyAbort", BUSY, 0);
    checkOutput("drain6", sbQ.size(), 0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    MAP_ACK = 1'b1;
    @(negedge CLK);
    MAP_ACK = 1'b0;
    monitorOn = 1'b1;
    repeat (15) @(negedge CLK);
    checkOutput("lateAckX", PLAYER_X, 1);
    checkOutput("lateAckY", PLAYER_Y, 1);
    checkOutput("lateAckReq", MAP_REQ, 0);
    checkOutput("lateAckBusy", BUSY, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, got hang, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
